// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, default address map and response-queue entry type
package bus_pkg;

  localparam int          IDX_W              = 4;
  localparam int          DATA_W             = 32;
  localparam logic [15:0] DEFAULT_SLAVE_MASK = 16'h01FD;

  // One outstanding transaction: which slave owes the response, or an error stub.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             unmapped;
  } rsp_entry_t;

endpackage

// File: rtl/bus_rsp_fifo.sv
// rtl/bus_rsp_fifo.sv - in-order queue of outstanding transactions (grant order)
module bus_rsp_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  rsp_entry_t push_data_i,
  input  logic       pop_i,
  output rsp_entry_t head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rsp_entry_t       mem_q [DEPTH];
  rsp_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: the caller never pushes when full nor pops when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - 1-to-N address-decoded interconnect with in-order responses; optional watchdog via BUS_TIMEOUT_EN
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int          NUM_SLAVES      = 8,
  parameter int          ADDR_LSB        = 13,
  parameter logic [15:0] SLAVE_MASK      = DEFAULT_SLAVE_MASK,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         data_req_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [DATA_W-1:0]            data_addr_i,
  input  logic [DATA_W-1:0]            data_wdata_i,
  output logic                         data_gnt_o,
  output logic                         data_rvalid_o,
  output logic                         data_err_o,
  output logic [DATA_W-1:0]            data_rdata_o,
  output logic [NUM_SLAVES-1:0]        s_req_o,
  output logic                         s_we_o,
  output logic [3:0]                   s_be_o,
  output logic [DATA_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES-1:0]        s_gnt_i,
  input  logic [NUM_SLAVES-1:0]        s_rvalid_i,
  input  logic [NUM_SLAVES-1:0]        s_err_i,
  input  logic [DATA_W*NUM_SLAVES-1:0] s_rdata_i
);

  logic [IDX_W-1:0]  req_idx;
  logic              req_mapped;
  logic              sel_gnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              timeout;
  rsp_entry_t        push_entry;
  rsp_entry_t        head;
  logic              head_rvalid;
  logic              head_err;
  logic [DATA_W-1:0] head_rdata;

  assign req_idx    = data_addr_i[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign req_mapped = (int'(req_idx) < NUM_SLAVES) && SLAVE_MASK[req_idx];

  assign s_we_o    = data_we_i;
  assign s_be_o    = data_be_i;
  assign s_addr_o  = data_addr_i;
  assign s_wdata_o = data_wdata_i;

  // Request side: select the addressed slave's grant and raise only its request line.
  always_comb begin
    sel_gnt = 1'b0;
    s_req_o = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      if (int'(req_idx) == n) begin
        sel_gnt    = s_gnt_i[n];
        s_req_o[n] = data_req_i & req_mapped & ~fifo_full & ~rst_i;
      end
    end
  end

  // Unmapped addresses are granted locally and answered with an error from the queue.
  assign data_gnt_o = data_req_i & ~fifo_full & ~rst_i & (req_mapped ? sel_gnt : 1'b1);

  assign push_entry.idx      = req_idx;
  assign push_entry.unmapped = ~req_mapped;

  bus_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (data_gnt_o),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Only the slave owing the head response is listened to; all others are ignored.
  always_comb begin
    head_rvalid = 1'b0;
    head_err    = 1'b0;
    head_rdata  = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      if (int'(head.idx) == n) begin
        head_rvalid = s_rvalid_i[n];
        head_err    = s_err_i[n];
        head_rdata  = s_rdata_i[n*DATA_W +: DATA_W];
      end
    end
  end

  // Response side: error stub for unmapped or timed-out heads, slave pass-through otherwise.
  always_comb begin
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    data_rdata_o  = '0;
    if (!fifo_empty) begin
      if (head.unmapped) begin
        data_rvalid_o = 1'b1;
        data_err_o    = 1'b1;
      end else if (head_rvalid) begin
        data_rvalid_o = 1'b1;
        data_err_o    = head_err;
        data_rdata_o  = head_rdata;
      end else if (timeout) begin
        data_rvalid_o = 1'b1;
        data_err_o    = 1'b1;
      end
    end
  end

  assign pop = data_rvalid_o;

`ifdef BUS_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;

  // Watchdog: count cycles a mapped head has waited; restart whenever the head leaves.
  always_comb begin
    wd_d = wd_q + 32'd1;
    if (pop || fifo_empty || head.unmapped) begin
      wd_d = '0;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout = ~fifo_empty & ~head.unmapped & (wd_q == 32'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - scoreboard bench for bus_interconnect
module tb_bus_interconnect;

  localparam int NS = 9;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            data_req_i;
  logic            data_we_i;
  logic [3:0]      data_be_i;
  logic [31:0]     data_addr_i;
  logic [31:0]     data_wdata_i;
  logic            data_gnt_o;
  logic            data_rvalid_o;
  logic            data_err_o;
  logic [31:0]     data_rdata_o;
  logic [NS-1:0]   s_req_o;
  logic            s_we_o;
  logic [3:0]      s_be_o;
  logic [31:0]     s_addr_o;
  logic [31:0]     s_wdata_o;
  logic [NS-1:0]   s_gnt_i;
  logic [NS-1:0]   s_rvalid_i;
  logic [NS-1:0]   s_err_i;
  logic [32*NS-1:0] s_rdata_i;

  always #5 clk_i = ~clk_i;

  bus_interconnect #(
    .NUM_SLAVES      (NS),
    .ADDR_LSB        (13),
    .SLAVE_MASK      (16'h01FD),
    .MAX_OUTSTANDING (2),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_err_o    (data_err_o),
    .data_rdata_o  (data_rdata_o),
    .s_req_o       (s_req_o),
    .s_we_o        (s_we_o),
    .s_be_o        (s_be_o),
    .s_addr_o      (s_addr_o),
    .s_wdata_o     (s_wdata_o),
    .s_gnt_i       (s_gnt_i),
    .s_rvalid_i    (s_rvalid_i),
    .s_err_i       (s_err_i),
    .s_rdata_i     (s_rdata_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic [31:0] addr);
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    data_addr_i  = addr;
    data_wdata_i = addr ^ 32'h5A5A_A5A5;
  endtask

  task automatic set_rdata(input int n, input logic [31:0] v);
    s_rdata_i[32*n +: 32] = v;
  endtask

  // Every delivered response is matched against the head of the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && data_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", data_rvalid_o, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", data_rdata_o, mon_e.rdata);
        check("rsp_err", data_err_o, mon_e.err);
      end
    end
  end

  initial begin
    rst_i        = 1'b1;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    s_gnt_i      = '1;
    s_rvalid_i   = '0;
    s_err_i      = '0;
    s_rdata_i    = '0;

    // Reset: a pending request must not be granted or forwarded.
    drive_req(32'h0000_4000);
    smp();
    check("rst_gnt", data_gnt_o, 1'b0);
    check("rst_sreq", s_req_o, '0);
    check("rst_rvalid", data_rvalid_o, 1'b0);
    cyc();
    rst_i      = 1'b0;
    data_req_i = 1'b0;
    s_gnt_i    = '0;
    smp();
    check("post_rst_rvalid", data_rvalid_o, 1'b0);
    check("post_rst_sreq", s_req_o, '0);

    // Read slave 2, response three cycles after grant.
    cyc();
    drive_req(32'h0000_4000);
    s_gnt_i = 9'b0_0000_0100;
    smp();
    check("t1_gnt", data_gnt_o, 1'b1);
    check("t1_sreq", s_req_o, 9'b0_0000_0100);
    check("t1_saddr", s_addr_o, 32'h0000_4000);
    check("t1_swdata", s_wdata_o, 32'h0000_4000 ^ 32'h5A5A_A5A5);
    check("t1_sbe", s_be_o, 4'hF);
    check("t1_swe", s_we_o, 1'b0);
    expect_rsp(32'hDEAD_BEEF, 1'b0);
    cyc();
    data_req_i = 1'b0;
    s_gnt_i    = '0;
    smp();
    check("t1_wait1", data_rvalid_o, 1'b0);
    cyc();
    smp();
    check("t1_wait2", data_rvalid_o, 1'b0);
    cyc();
    s_rvalid_i[2] = 1'b1;
    set_rdata(2, 32'hDEAD_BEEF);
    smp();
    check("t1_rvalid", data_rvalid_o, 1'b1);
    cyc();
    s_rvalid_i = '0;
    smp();
    check("t1_done", data_rvalid_o, 1'b0);

    // Unmapped slave 1: local grant, error response next cycle, no slave request.
    cyc();
    drive_req(32'h0000_2000);
    smp();
    check("t2_gnt", data_gnt_o, 1'b1);
    check("t2_sreq", s_req_o, '0);
    expect_rsp(32'h0, 1'b1);
    cyc();
    data_req_i = 1'b0;
    smp();
    check("t2_rvalid", data_rvalid_o, 1'b1);
    cyc();

    // Slave 0 then slave 8; slave 8 answers first but must wait its turn.
    s_gnt_i = '1;
    drive_req(32'h0000_0000);
    smp();
    check("t3_gnt0", data_gnt_o, 1'b1);
    expect_rsp(32'h1111_0000, 1'b0);
    cyc();
    drive_req(32'h0001_0000);
    smp();
    check("t3_gnt8", data_gnt_o, 1'b1);
    check("t3_sreq8", s_req_o, 9'b1_0000_0000);
    expect_rsp(32'h8888_8888, 1'b0);
    cyc();
    data_req_i    = 1'b0;
    s_rvalid_i[8] = 1'b1;
    set_rdata(8, 32'h8888_8888);
    smp();
    check("t3_hold_a", data_rvalid_o, 1'b0);
    cyc();
    smp();
    check("t3_hold_b", data_rvalid_o, 1'b0);
    cyc();
    s_rvalid_i[0] = 1'b1;
    set_rdata(0, 32'h1111_0000);
    smp();
    check("t3_first", data_rvalid_o, 1'b1);
    cyc();
    s_rvalid_i[0] = 1'b0;
    smp();
    check("t3_second", data_rvalid_o, 1'b1);
    cyc();
    s_rvalid_i = '0;
    smp();
    check("t3_drained", exp_q.size(), 0);

    // Queue depth 2: third request stalls until one cycle after the first response.
    cyc();
    drive_req(32'h0000_0000);
    smp();
    check("t4_gnt1", data_gnt_o, 1'b1);
    expect_rsp(32'hAAAA_0001, 1'b0);
    cyc();
    drive_req(32'h0000_4000);
    smp();
    check("t4_gnt2", data_gnt_o, 1'b1);
    expect_rsp(32'hBBBB_0002, 1'b0);
    cyc();
    drive_req(32'h0000_6000);
    smp();
    check("t4_full_gnt", data_gnt_o, 1'b0);
    check("t4_full_sreq", s_req_o, '0);
    cyc();
    smp();
    check("t4_full_gnt_b", data_gnt_o, 1'b0);
    cyc();
    s_rvalid_i[0] = 1'b1;
    set_rdata(0, 32'hAAAA_0001);
    smp();
    check("t4_pop_cycle_gnt", data_gnt_o, 1'b0);
    cyc();
    s_rvalid_i[0] = 1'b0;
    smp();
    check("t4_gnt3", data_gnt_o, 1'b1);
    check("t4_sreq3", s_req_o, 9'b0_0000_1000);
    expect_rsp(32'hCCCC_0003, 1'b0);
    cyc();
    data_req_i    = 1'b0;
    s_rvalid_i[2] = 1'b1;
    set_rdata(2, 32'hBBBB_0002);
    cyc();
    s_rvalid_i[2] = 1'b0;
    s_rvalid_i[3] = 1'b1;
    set_rdata(3, 32'hCCCC_0003);
    cyc();
    s_rvalid_i = '0;
    smp();
    check("t4_drained", exp_q.size(), 0);

    // Reset with two transactions outstanding; stale responses must be dropped.
    cyc();
    drive_req(32'h0000_0000);
    smp();
    check("t5_gnt_a", data_gnt_o, 1'b1);
    cyc();
    drive_req(32'h0000_4000);
    smp();
    check("t5_gnt_b", data_gnt_o, 1'b1);
    cyc();
    data_req_i = 1'b0;
    rst_i      = 1'b1;
    cyc();
    rst_i      = 1'b0;
    s_rvalid_i = '1;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("t5_stale_rvalid", data_rvalid_o, 1'b0);
      check("t5_stale_sreq", s_req_o, '0);
      cyc();
    end
    s_rvalid_i = '0;

    // Normal traffic resumes after reset (slave 5).
    drive_req(32'h0000_A000);
    smp();
    check("t5_recover_gnt", data_gnt_o, 1'b1);
    expect_rsp(32'h5555_AAAA, 1'b0);
    cyc();
    data_req_i    = 1'b0;
    s_rvalid_i[5] = 1'b1;
    set_rdata(5, 32'h5555_AAAA);
    smp();
    check("t5_recover_rvalid", data_rvalid_o, 1'b1);
    cyc();
    s_rvalid_i = '0;

`ifdef BUS_TIMEOUT_EN
    // Silent slave 4: forced error exactly 16 cycles after reaching the head.
    drive_req(32'h0000_8000);
    smp();
    check("t6_gnt", data_gnt_o, 1'b1);
    expect_rsp(32'h0, 1'b1);
    cyc();
    data_req_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      smp();
      check("t6_waiting", data_rvalid_o, 1'b0);
      cyc();
    end
    smp();
    check("t6_timeout", data_rvalid_o, 1'b1);
    cyc();
`endif

    cyc();
    smp();
    check("final_drained", exp_q.size(), 0);
    check("final_idle_rvalid", data_rvalid_o, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of slave ports (1..16).
REQ-002 SHALL have parameter ADDR_LSB, default 13, lowest address bit of the slave-select field.
REQ-003 SHALL have parameter SLAVE_MASK, default 16'h01FD, bit n=1 marks slave n as mapped.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, response-FIFO depth (1..8).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (used only with BUS_TIMEOUT_EN).
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports clk_i (in, 1, clock) and rst_i (in, 1, reset).
REQ-007 SHALL have master ports data_req_i, data_we_i (in, 1), data_be_i (in, 4), data_addr_i and data_wdata_i (in, 32).
REQ-008 SHALL have master ports data_gnt_o, data_rvalid_o, data_err_o (out, 1) and data_rdata_o (out, 32).
REQ-009 SHALL have slave ports s_req_o (out, NUM_SLAVES) plus broadcast s_we_o (out, 1), s_be_o (out, 4), s_addr_o and s_wdata_o (out, 32).
REQ-010 SHALL have slave ports s_gnt_i, s_rvalid_i, s_err_i (in, NUM_SLAVES) and s_rdata_i (in, 32*NUM_SLAVES, slave n at bits [32n+31:32n]).

Function
REQ-011 SHALL decode idx = data_addr_i[ADDR_LSB+3:ADDR_LSB]; mapped = (idx < NUM_SLAVES) & SLAVE_MASK[idx].
REQ-012 SHALL drive s_we_o/s_be_o/s_addr_o/s_wdata_o combinationally equal to the master inputs.
REQ-013 SHALL assert s_req_o[idx] = data_req_i & mapped & !fifo_full, with all other bits 0.
REQ-014 SHALL drive data_gnt_o = data_req_i & !fifo_full & (mapped ? s_gnt_i[idx] : 1), combinationally in the request cycle.
REQ-015 SHALL push {idx, unmapped} into the response FIFO on each data_req_i & data_gnt_o cycle.
REQ-016 SHALL return responses strictly in grant order, taken from the FIFO head only.
REQ-017 SHALL, for a mapped head, pass s_rvalid_i/s_rdata_i/s_err_i of slave head_idx combinationally to data_rvalid_o/data_rdata_o/data_err_o.
REQ-018 SHALL, for an unmapped head, assert data_rvalid_o=1, data_err_o=1, data_rdata_o=0 in the first cycle that entry is at the head (minimum 1 cycle after grant).
REQ-019 SHALL ignore s_rvalid_i from any slave other than head_idx and ignore all s_rvalid_i while the FIFO is empty.
REQ-020 SHALL pop the head in each cycle data_rvalid_o=1.
REQ-021 SHALL evaluate fifo_full on the registered count only, so a pop in the same cycle does not free a slot for that cycle's grant.
REQ-022 SHALL hold data_rvalid_o=0, data_err_o=0, data_rdata_o=0 when the FIFO is empty.
REQ-023 SHALL wrap the FIFO read and write pointers modulo MAX_OUTSTANDING.

Reset
REQ-024 SHALL, on rst_i=1 at a clk_i edge, clear the FIFO pointers and count and the watchdog counter, discarding in-flight transactions.
REQ-025 SHALL, while and after reset, drive data_gnt_o=0 during rst_i, and s_req_o=0 and data_rvalid_o=0 until new grants occur.

Configuration
REQ-026 SHALL, with BUS_TIMEOUT_EN defined, count the cycles a mapped head waits without rvalid; on reaching TIMEOUT_CYCLES it SHALL force data_rvalid_o=1, data_err_o=1, data_rdata_o=0 and pop that head.
REQ-027 SHALL reset the watchdog counter on every pop, and the bench SHALL treat a late rvalid from a timed-out slave as a slave protocol error.
REQ-028 SHALL, without BUS_TIMEOUT_EN, contain no watchdog logic and never time out.

Structure
REQ-029 SHALL keep the slave-index width (4), the data width (32) and the default SLAVE_MASK in package bus_pkg.
REQ-030 SHALL implement the response queue as a sub-module bus_rsp_fifo (parametrised depth, payload = idx + unmapped bit).

Verification
REQ-031 SHALL cover: read 0x0000_4000 (slave 2), slave gnt at once, rvalid 3 cycles later with rdata 0xDEADBEEF -> data_rdata_o=0xDEADBEEF, err=0.
REQ-032 SHALL cover: access 0x0000_2000 (slave 1, unmapped) -> gnt in the same cycle, next cycle rvalid=1, err=1, rdata=0, no s_req_o bit set.
REQ-033 SHALL cover: back-to-back reads to slave 0 then slave 8, slave 8 answering first -> no response until slave 0 answers, then both delivered in order.
REQ-034 SHALL cover: 3 requests with MAX_OUTSTANDING=2 and no responses -> third gnt=0 until the first rvalid plus 1 cycle.
REQ-035 SHALL cover: rst_i pulsed with 2 transactions outstanding, then stale s_rvalid_i -> no data_rvalid_o.
REQ-036 SHALL cover, with BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16: a slave that never answers -> rvalid=1, err=1 exactly 16 cycles after the entry reaches the head.
